fc_backward_seq: RTL and testbench

- Reverse-direction companion to the combinational fully-connected forward layer in the layers library.
- Computes the input gradient dX[j] = sum over i of W[i][j] * dY[i], which is the transpose product of the forward layer.
- Uses the same packed weight layout as the forward layer.
- Time-multiplexed: one signed MAC per cycle, with a start/done handshake, so it is small enough to sit beside the forward layer in the training datapath.

---
 rtl/nn_pkg.sv | 35 +++
 rtl/fc_backward_seq_if.sv | 19 +
 rtl/fc_backward_seq_mac_sat.sv | 37 +++
 rtl/fc_backward_seq.sv | 119 +++++++++++
 tb/tb_fc_backward_seq.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared sizing, saturation, FSM state and weight-index helpers
// Purpose: common definitions for the nn layer blocks (forward and backward).
// Ports: none (package).
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_state_e;

  // Accumulator width that can hold output_size full-scale products without wrapping.
  function automatic int acc_width(input int bitwidth, input int output_size);
    return 2 * bitwidth + $clog2(output_size);
  endfunction

  // Clamp v into the signed out_w-bit range. The result is returned sign-extended;
  // callers cast it down to out_w bits.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                    input int out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Element index of W[i][j] in the packed weight bus (multiply by BITWIDTH for the LSB).
  function automatic int w_idx(input int i, input int j, input int input_size);
    return i * input_size + j;
  endfunction

endpackage

// File: rtl/fc_backward_seq_if.sv
// rtl/fc_backward_seq_if.sv - operand/result bundle of the backward FC sequencer
// Purpose: groups the start/busy/done handshake with the operand and result buses.
// Signals: start, grad_out (dY), weight (W) from the master; busy, done,
//          grad_in (dX) from the slave.
interface fc_backward_seq_if #(
  parameter int BITWIDTH    = 8,
  parameter int INPUT_SIZE  = 7,
  parameter int OUTPUT_SIZE = 5
);
  logic                                       start;
  logic [BITWIDTH*OUTPUT_SIZE-1:0]            grad_out;
  logic [BITWIDTH*INPUT_SIZE*OUTPUT_SIZE-1:0] weight;
  logic                                       busy;
  logic                                       done;
  logic [2*BITWIDTH*INPUT_SIZE-1:0]           grad_in;

  modport master (output start, grad_out, weight, input busy, done, grad_in);
  modport slave  (input start, grad_out, weight, output busy, done, grad_in);
endinterface

// File: rtl/fc_backward_seq_mac_sat.sv
// rtl/fc_backward_seq_mac_sat.sv - signed MAC with clear and saturated sum view
// Purpose: accumulates a*b each enabled cycle; sum_sat shows acc+a*b clamped to 2*BW bits.
// Ports: clk, rst (sync active-high), clr (zero acc, wins over en), en (accumulate),
//        a, b (signed BW), sum_sat (signed 2*BW).
module mac_sat
  import nn_pkg::*;
#(
  parameter int BW    = 8,
  parameter int ACC_W = 19
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   en,
  input  logic signed [BW-1:0]   a,
  input  logic signed [BW-1:0]   b,
  output logic signed [2*BW-1:0] sum_sat
);
  logic signed [2*BW-1:0]  prod;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  assign prod    = (2*BW)'(a) * (2*BW)'(b);
  assign sum     = acc_q + ACC_W'(prod);
  assign sum_sat = (2*BW)'(sat_signed(64'(sum), 2 * BW));

  always_comb begin
    acc_d = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = sum;
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end
endmodule

// File: rtl/fc_backward_seq.sv
// rtl/fc_backward_seq.sv - time-multiplexed transpose product dX = W^T * dY
// Purpose: one signed MAC per cycle over j (outer) and i (inner), saturated results
//          published on grad_in together with a one-cycle done pulse.
// Ports: clk, rst (sync active-high), bus (slave side of fc_backward_seq_if).
module fc_backward_seq
  import nn_pkg::*;
#(
  parameter int BITWIDTH    = 8,
  parameter int INPUT_SIZE  = 7,
  parameter int OUTPUT_SIZE = 5
) (
  input logic               clk,
  input logic               rst,
  fc_backward_seq_if.slave  bus
);
  localparam int ACC_W = acc_width(BITWIDTH, OUTPUT_SIZE);
  localparam int RES_W = 2 * BITWIDTH;
  localparam int I_W   = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
  localparam int J_W   = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam logic [I_W-1:0] I_LAST = I_W'(OUTPUT_SIZE - 1);
  localparam logic [J_W-1:0] J_LAST = J_W'(INPUT_SIZE - 1);

  fsm_state_e                  state_q, state_d;
  logic [I_W-1:0]              i_q, i_d;
  logic [J_W-1:0]              j_q, j_d;
  logic signed [BITWIDTH-1:0]  dy_q [OUTPUT_SIZE];
  logic signed [BITWIDTH-1:0]  dy_d [OUTPUT_SIZE];
  logic signed [BITWIDTH-1:0]  w_q  [OUTPUT_SIZE][INPUT_SIZE];
  logic signed [BITWIDTH-1:0]  w_d  [OUTPUT_SIZE][INPUT_SIZE];
  logic signed [RES_W-1:0]     buf_q [INPUT_SIZE];
  logic signed [RES_W-1:0]     buf_d [INPUT_SIZE];
  logic [RES_W*INPUT_SIZE-1:0] grad_in_q, grad_in_d;

  logic                    accept, col_end, last_mac;
  logic signed [RES_W-1:0] sum_sat;

  assign accept   = (state_q == IDLE) && bus.start;
  assign col_end  = (state_q == RUN) && (i_q == I_LAST);
  assign last_mac = col_end && (j_q == J_LAST);

  // Accumulator restarts on acceptance and after every column's write-out.
  mac_sat #(.BW(BITWIDTH), .ACC_W(ACC_W)) u_mac (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept || col_end),
    .en      (state_q == RUN),
    .a       (w_q[i_q][j_q]),
    .b       (dy_q[i_q]),
    .sum_sat (sum_sat)
  );

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    dy_d      = dy_q;
    w_d       = w_q;
    buf_d     = buf_q;
    grad_in_d = grad_in_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          for (int oi = 0; oi < OUTPUT_SIZE; oi++) begin
            dy_d[oi] = bus.grad_out[oi*BITWIDTH +: BITWIDTH];
            for (int oj = 0; oj < INPUT_SIZE; oj++)
              w_d[oi][oj] = bus.weight[w_idx(oi, oj, INPUT_SIZE)*BITWIDTH +: BITWIDTH];
          end
          i_d     = '0;
          j_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (col_end) begin
          buf_d[j_q] = sum_sat;
          i_d        = '0;
          j_d        = j_q + J_W'(1);
          if (last_mac) begin
            j_d     = '0;
            state_d = DONE;
            // Publish from buf_d so the final column written this cycle is included.
            for (int oj = 0; oj < INPUT_SIZE; oj++)
              grad_in_d[oj*RES_W +: RES_W] = buf_d[oj];
          end
        end else begin
          i_d = i_q + I_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      i_q       <= '0;
      j_q       <= '0;
      grad_in_q <= '0;
      for (int oi = 0; oi < OUTPUT_SIZE; oi++) begin
        dy_q[oi] <= '0;
        for (int oj = 0; oj < INPUT_SIZE; oj++) w_q[oi][oj] <= '0;
      end
      for (int oj = 0; oj < INPUT_SIZE; oj++) buf_q[oj] <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      grad_in_q <= grad_in_d;
      dy_q      <= dy_d;
      w_q       <= w_d;
      buf_q     <= buf_d;
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.grad_in = grad_in_q;
endmodule

// File: tb/tb_fc_backward_seq.sv
// tb/tb_fc_backward_seq.sv - scoreboard bench for fc_backward_seq
module tb_fc_backward_seq;
  localparam int BW  = 8;
  localparam int IN  = 7;
  localparam int OUT = 5;
  localparam int RW  = 2 * BW;
  localparam int N   = IN * OUT;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fc_backward_seq_if #(.BITWIDTH(BW), .INPUT_SIZE(IN), .OUTPUT_SIZE(OUT)) bus ();
  fc_backward_seq #(.BITWIDTH(BW), .INPUT_SIZE(IN), .OUTPUT_SIZE(OUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fc_backward_seq_if #(.BITWIDTH(BW), .INPUT_SIZE(3), .OUTPUT_SIZE(1)) bus1 ();
  fc_backward_seq #(.BITWIDTH(BW), .INPUT_SIZE(3), .OUTPUT_SIZE(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  typedef struct {
    logic [RW*IN-1:0] gi;
    int               cyc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void chk(input string name, input logic [127:0] act,
                              input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic logic [RW*IN-1:0] pack_res(input int e[IN]);
    logic [RW*IN-1:0] r;
    for (int j = 0; j < IN; j++) r[j*RW +: RW] = RW'(e[j]);
    return r;
  endfunction

  function automatic logic [RW*IN-1:0] pack_all(input int v);
    logic [RW*IN-1:0] r;
    for (int j = 0; j < IN; j++) r[j*RW +: RW] = RW'(v);
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest expected result and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (bus.done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at cycle %0d, required no done", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("done_cycle", 128'(cyc), 128'(e.cyc));
        chk("grad_in", 128'(bus.grad_in), 128'(e.gi));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk) #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(posedge clk) #1;
  endtask

  task automatic set_uniform(input int w, input int dy);
    for (int i = 0; i < OUT; i++) begin
      bus.grad_out[i*BW +: BW] = BW'(dy);
      for (int j = 0; j < IN; j++) bus.weight[(i*IN+j)*BW +: BW] = BW'(w);
    end
  endtask

  task automatic set_identity(input int dy[OUT]);
    bus.weight = '0;
    for (int i = 0; i < OUT; i++) begin
      bus.grad_out[i*BW +: BW]      = BW'(dy[i]);
      bus.weight[(i*IN+i)*BW +: BW] = BW'(1);
    end
  endtask

  task automatic pulse_start(output int t);
    bus.start = 1'b1;
    t = cyc;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic push_exp(input logic [RW*IN-1:0] gi, input int c);
    exp_t e;
    e.gi  = gi;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  initial begin
    int t;
    int t2;
    int id_dy[OUT];
    int id_res[IN];
    id_dy  = '{1, -2, 3, -4, 5};
    id_res = '{1, -2, 3, -4, 5, 0, 0};

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.grad_out = '0;
    bus.weight = '0;
    bus1.start = 1'b0;
    bus1.grad_out = '0;
    bus1.weight = '0;
    tick(2);
    chk("reset_busy", 128'(bus.busy), 128'(0));
    chk("reset_done", 128'(bus.done), 128'(0));
    chk("reset_grad_in", 128'(bus.grad_in), 128'(0));
    rst = 1'b0;
    tick(1);

    // All ones, dY=2: each column sums 5*2.
    set_uniform(1, 2);
    chk("busy_before_start", 128'(bus.busy), 128'(0));
    pulse_start(t);
    push_exp(pack_all(10), t + N + 1);
    chk("busy_t_plus_1", 128'(bus.busy), 128'(1));
    wait_cyc(t + 35);
    chk("busy_t_plus_35", 128'(bus.busy), 128'(1));
    wait_cyc(t + 36);
    chk("busy_t_plus_36", 128'(bus.busy), 128'(1));
    wait_cyc(t + 37);
    chk("busy_t_plus_37", 128'(bus.busy), 128'(0));

    // Identity weights pass dY straight through; the two extra columns are zero.
    set_identity(id_dy);
    pulse_start(t);
    push_exp(pack_res(id_res), t + N + 1);
    wait_cyc(t + 38);

    // Positive saturation: 5 * 16384 = 81920.
    set_uniform(-128, -128);
    pulse_start(t);
    push_exp(pack_all(32767), t + N + 1);
    wait_cyc(t + 38);

    // Negative saturation: 5 * -16256 = -81280.
    set_uniform(-128, 127);
    pulse_start(t);
    push_exp(pack_all(-32768), t + N + 1);
    wait_cyc(t + 38);

    // Second start during RUN (zero operands) is ignored.
    set_identity(id_dy);
    pulse_start(t);
    push_exp(pack_res(id_res), t + N + 1);
    set_uniform(0, 0);
    wait_cyc(t + 10);
    pulse_start(t2);
    wait_cyc(t + 45);
    chk("no_extra_done", 128'(exp_q.size()), 128'(0));

    // Reset mid-run aborts with no done; a fresh run then completes.
    set_uniform(3, -1);
    pulse_start(t);
    wait_cyc(t + 20);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("abort_busy", 128'(bus.busy), 128'(0));
    chk("abort_done", 128'(bus.done), 128'(0));
    chk("abort_grad_in", 128'(bus.grad_in), 128'(0));
    wait_cyc(t + 25);
    set_uniform(2, 3);
    pulse_start(t2);
    push_exp(pack_all(30), t + 61);
    wait_cyc(t + 40);
    chk("abort_grad_in_hold", 128'(bus.grad_in), 128'(0));
    wait_cyc(t + 63);

    // Start held high: accepted at t and t+37; operands changed after t feed the second run.
    set_uniform(-128, 127);
    bus.start = 1'b1;
    t = cyc;
    push_exp(pack_all(-32768), t + N + 1);
    push_exp(pack_all(32767), t + 2 * (N + 1) + 1);
    tick(1);
    set_uniform(-128, -128);
    wait_cyc(t + 38);
    bus.start = 1'b0;
    chk("b2b_busy_second", 128'(bus.busy), 128'(1));
    wait_cyc(t + 72);
    chk("b2b_grad_in_hold", 128'(bus.grad_in), 128'(pack_all(-32768)));
    wait_cyc(t + 76);

    // Single-row instance: every MAC is a column end. W=[2,-3,4], dY=5 -> [10,-15,20].
    bus1.weight   = {8'sd4, -8'sd3, 8'sd2};
    bus1.grad_out = 8'sd5;
    bus1.start    = 1'b1;
    t = cyc;
    tick(1);
    bus1.start = 1'b0;
    wait_cyc(t + 3);
    chk("small_done_early", 128'(bus1.done), 128'(0));
    wait_cyc(t + 4);
    chk("small_done", 128'(bus1.done), 128'(1));
    chk("small_grad_in", 128'(bus1.grad_in), 128'({16'sd20, -16'sd15, 16'sd10}));

    for (int k = 0; k < 200 && exp_q.size() > 0; k++) tick(1);
    chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
